uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered, frame-configurable UART transmitter; next generation of the system UART send port.
//  Accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first.
//  Data width, parity and stop-bit count are parameters; back-to-back frames leave no idle gap.
//  Sits between the CPU MMIO/loader logic and the board TX pin.
// PARAMETERS
//  CLK_PER_HALF_BIT  434  half bit period in clk cycles; bit period BIT_CYC = 2*CLK_PER_HALF_BIT (>=2)
//  DATA_BITS         8    data bits per frame, legal 5..9
//  PARITY            0    uart_pkg::parity_e: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
//  STOP_BITS         1    stop bits per frame, legal 1 or 2
//  FIFO_DEPTH        16   FIFO entries, power of two, >=2
// PORTS
//  clk         in   1                     system clock
//  rstn        in   1                     synchronous reset, active-low
//  s_data      in   DATA_BITS             word to send
//  s_valid     in   1                     s_data valid
//  s_ready     out  1                     FIFO not full; transfer when s_valid && s_ready
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words held in FIFO (excludes word in shifter)
//  tx_busy     out  1                     frame in progress or FIFO non-empty
//  txd         out  1                     serial line, idle high
// BEHAVIOUR
//  Reset: txd=1, tx_busy=0, s_ready=1, fifo_count=0, FSM=S_IDLE, FIFO emptied; rstn low mid-frame
//   aborts the frame, txd returns high on the next edge, and buffered words are discarded.
//  FIFO: push on s_valid&&s_ready; s_ready=(fifo_count!=FIFO_DEPTH), registered from count.
//   s_valid while full is ignored (no overwrite, count unchanged). Push and pop in the same
//   cycle: count unchanged. Pointers wrap mod FIFO_DEPTH.
//  FSM (uart_pkg::tx_state_e): S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
//   S_IDLE: if FIFO non-empty -> pop, load shifter, txd<=0, -> S_START.
//   S_START: BIT_CYC cycles, then txd<=shift[0] -> S_DATA.
//   S_DATA: each bit lasts BIT_CYC cycles. After DATA_BITS bits -> S_PARITY (PARITY!=NONE) else S_STOP.
//   S_PARITY: txd = ^data (EVEN) or ~^data (ODD) for BIT_CYC cycles -> S_STOP.
//   S_STOP: txd=1 for STOP_BITS*BIT_CYC cycles; at end, if FIFO non-empty, pop and txd<=0 in
//    the same cycle (next start bit directly follows the stop bit); else -> S_IDLE.
//  Latency: word pushed at edge N into an idle, empty block -> txd low from edge N+2.
//  Frame length exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BIT_CYC cycles; each bit level
//   held exactly BIT_CYC cycles, no jitter. Bit counter reloads on every state transition.
//  Baud counter width $clog2(BIT_CYC); counts 0..BIT_CYC-1 and holds 0 in S_IDLE.
//  tx_busy = (state!=S_IDLE) || (fifo_count!=0), registered; falls on the edge txd completes the
//   last stop bit with the FIFO empty.
//  Parity is computed from the popped word at load time, not from the shifting register.
//  Elaboration error ($error) on illegal DATA_BITS, STOP_BITS, PARITY or FIFO_DEPTH.
// STRUCTURE
//  uart_pkg: parity_e, tx_state_e, localparam helpers (frame_len function).
//  Sub-module sync_fifo #(WIDTH,DEPTH): single-clock FIFO with push/pop/count/full/empty;
//   reusable by the planned uart_rx_fifo. Shifter, baud counter and FSM stay in uart_tx_fifo.
// TESTING (CLK_PER_HALF_BIT=4 -> BIT_CYC=8 unless stated)
//  1 8N1, push 0xA5 at edge 10 -> txd low edges 12..19, then bits 1,0,1,0,0,1,0,1 for 8 cycles each,
//    stop high edges 84..91, tx_busy falls at edge 92.
//  2 8E2 / 8O1, send 0x07 -> parity bit 1 (even) / 0 (odd); frame 96 / 88 cycles; stop width checked.
//  3 7N1, burst 0x41,0x42,0x43 back-to-back -> three 72-cycle frames, no idle cycle between stop and start.
//  4 FIFO_DEPTH=4, hold s_valid 10 cycles while txd busy -> s_ready=0 at count 4, extra words
//    dropped, exactly 1 (shifter) + 4 frames sent in order.
//  5 rstn low 1 cycle mid data bit of 0x55 with 3 queued -> txd=1, fifo_count=0, tx_busy=0 next
//    edge; no further frames.
//  6 Scoreboard: random DATA_BITS/PARITY/STOP_BITS configs, 200 random words, bus-level
//    decoder checks data, parity, framing and BIT_CYC timing.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: frame parity, transmitter FSM states and frame sizing.
// Imported by the transmit block and its testbench.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    function automatic int frame_len(
        input int      data_bits,
        input parity_e par,
        input int      stop_bits,
        input int      bit_cyc
    );
        int pbits;
        pbits = (par != PAR_NONE) ? 1 : 0;
        return (1 + data_bits + pbits + stop_bits) * bit_cyc;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count and a registered full flag.
// Written to serve both the UART transmit and receive paths.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL);
        end
    end

    // Storage carries no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: stream words into a FIFO, serialise LSB-first
// with configurable data width, parity and stop bits; frames run back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_PER_HALF_BIT = 434,
    parameter int      DATA_BITS        = 8,
    parameter parity_e PARITY           = PAR_NONE,
    parameter int      STOP_BITS        = 1,
    parameter int      FIFO_DEPTH       = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_BITS-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_busy,
    output logic                        txd
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
        $error("uart_tx_fifo: PARITY must be NONE, EVEN or ODD");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (CLK_PER_HALF_BIT < 1) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_PER_HALF_BIT must be >= 1");
    end

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 have_q;

    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    assign push    = s_valid && s_ready;
    assign s_ready = !fifo_full;
    assign tick    = (cnt_q == CNT_LAST);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (s_valid),
        .wdata_i (s_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            have_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            have_q  <= !fifo_empty;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (have_q) state_d = S_START;
            S_START:  if (tick) state_d = S_DATA;
            S_DATA: begin
                if (tick && bit_q == DATA_LAST) begin
                    state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (tick) state_d = S_STOP;
            S_STOP: begin
                if (tick && bit_q == STOP_LAST) begin
                    state_d = have_q ? S_START : S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Parity is fixed from the popped word, independent of the shifter.
    always_comb begin
        pop     = (state_d == S_START) && (state_q != S_START);
        txd_d   = txd_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == S_IDLE || tick) cnt_d = '0;
        else                           cnt_d = cnt_q + 1'b1;
        if (state_d != state_q) bit_d = '0;
        else if (tick)          bit_d = bit_q + 1'b1;
        else                    bit_d = bit_q;
        if (pop) begin
            txd_d   = 1'b0;
            shift_d = fifo_rdata;
            par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
        end else if (tick) begin
            unique case (state_d)
                S_DATA: begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                S_PARITY: txd_d = par_q;
                default:  txd_d = 1'b1;
            endcase
        end
        busy_d = (state_d != S_IDLE) || (fifo_count != '0) || push;
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;

endmodule
